// File: rtl/perceptron_predictor.sv
// Perceptron conditional-branch predictor with a direct-mapped tagged BTB.
// Fetch prediction is combinational; training, history and BTB writes commit on the clock edge.
module perceptron_predictor #(
  parameter int unsigned NUM_PERCEPTRONS = 64,
  parameter int unsigned HIST_LEN        = 16,
  parameter int unsigned WEIGHT_W        = 8,
  parameter int unsigned THETA           = 44,
  parameter int unsigned BTB_ENTRIES     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetchPc,
  output logic        fetchHit,
  output logic [31:0] fetchTarget,
  input  logic [31:0] exPc,
  input  logic        exBranch,
  input  logic        exTaken,
  input  logic [31:0] exTarget,
  output logic [31:0] branchCount,
  output logic [31:0] mispredCount
);
  localparam int unsigned ROW_W = $clog2(NUM_PERCEPTRONS);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned NUM_W = HIST_LEN + 1;
  localparam int unsigned SUM_W = WEIGHT_W + $clog2(HIST_LEN + 2) + 1;
  localparam int unsigned WX_W  = WEIGHT_W + 1;
  localparam logic signed [WX_W-1:0] W_MAX = WX_W'((1 << (WEIGHT_W - 1)) - 1);
  localparam logic signed [WX_W-1:0] W_MIN = -W_MAX;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic             jmp;
  } btbEntry_t;

  logic signed [WEIGHT_W-1:0] weights [NUM_PERCEPTRONS][NUM_W];
  btbEntry_t                  btb [BTB_ENTRIES];
  logic [HIST_LEN-1:0]        ghr;

  logic [ROW_W-1:0] fetchRow, exRow;
  logic [IDX_W-1:0] fetchIdx, exIdx;
  logic [TAG_W-1:0] fetchTag, exTag;
  logic             unusedPcBits;

  assign fetchRow     = fetchPc[ROW_W+1:2];
  assign exRow        = exPc[ROW_W+1:2];
  assign fetchIdx     = fetchPc[IDX_W+1:2];
  assign exIdx        = exPc[IDX_W+1:2];
  assign fetchTag     = fetchPc[31:IDX_W+2];
  assign exTag        = exPc[31:IDX_W+2];
  assign unusedPcBits = ^{fetchPc[1:0], exPc[1:0]};

  // Bias plus history-signed weights; wide enough that no intermediate sum can overflow.
  function automatic logic signed [SUM_W-1:0] dotProduct(
    input logic signed [WEIGHT_W-1:0] row [NUM_W],
    input logic [HIST_LEN-1:0]        hist
  );
    logic signed [SUM_W-1:0] acc;
    acc = SUM_W'(row[0]);
    for (int i = 0; i < HIST_LEN; i++) begin
      if (hist[i]) acc = acc + SUM_W'(row[i+1]);
      else         acc = acc - SUM_W'(row[i+1]);
    end
    return acc;
  endfunction

  logic signed [SUM_W-1:0] fetchY;
  btbEntry_t               fetchEntry;
  logic                    fetchBtbHit;

  always_comb begin
    fetchEntry  = btb[fetchIdx];
    fetchY      = dotProduct(weights[fetchRow], ghr);
    fetchBtbHit = fetchEntry.valid && (fetchEntry.tag == fetchTag);
    fetchHit    = fetchBtbHit && (fetchEntry.jmp || !fetchY[SUM_W-1]);
    fetchTarget = fetchBtbHit ? fetchEntry.target : 32'd0;
  end

  logic signed [SUM_W-1:0]    exY;
  logic [SUM_W-1:0]           exAbsY;
  logic                       exPredTaken, exMispred, exTrain;
  logic [NUM_W-1:0]           incVec;
  logic signed [WX_W-1:0]     wide;
  logic signed [WEIGHT_W-1:0] nextWeights [NUM_W];
  logic [HIST_LEN-1:0]        nextGhr;

  // Training decision and saturated next weights for the resolving row.
  always_comb begin
    exY         = dotProduct(weights[exRow], ghr);
    exPredTaken = !exY[SUM_W-1];
    exAbsY      = exPredTaken ? exY : -exY;
    exMispred   = exPredTaken != exTaken;
    exTrain     = exMispred || (exAbsY <= SUM_W'(THETA));
    incVec      = {~(ghr ^ {HIST_LEN{exTaken}}), exTaken};
    wide        = '0;
    for (int j = 0; j < NUM_W; j++) begin
      wide = WX_W'(weights[exRow][j]);
      wide = incVec[j] ? wide + WX_W'(1) : wide - WX_W'(1);
      if (wide > W_MAX)      wide = W_MAX;
      else if (wide < W_MIN) wide = W_MIN;
      nextWeights[j] = WEIGHT_W'(wide);
    end
  end

  generate
    if (HIST_LEN == 1) begin : gSingleHist
      assign nextGhr = exTaken;
    end else begin : gMultiHist
      assign nextGhr = {ghr[HIST_LEN-2:0], exTaken};
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_PERCEPTRONS; r++)
        for (int j = 0; j < NUM_W; j++)
          weights[r][j] <= '0;
      for (int e = 0; e < BTB_ENTRIES; e++)
        btb[e] <= '0;
      ghr          <= '0;
      branchCount  <= '0;
      mispredCount <= '0;
    end else begin
      if (exTaken)
        btb[exIdx] <= '{valid: 1'b1, tag: exTag, target: exTarget, jmp: !exBranch};
      if (exBranch) begin
        if (exTrain)
          for (int j = 0; j < NUM_W; j++)
            weights[exRow][j] <= nextWeights[j];
        ghr         <= nextGhr;
        branchCount <= branchCount + 32'd1;
        if (exMispred)
          mispredCount <= mispredCount + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_perceptron_predictor.sv
// Scoreboard bench for perceptron_predictor: driver pushes model expectations, monitor compares at negedge.
module tb_perceptron_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetchPc;
  logic        fetchHit;
  logic [31:0] fetchTarget;
  logic [31:0] exPc;
  logic        exBranch;
  logic        exTaken;
  logic [31:0] exTarget;
  logic [31:0] branchCount;
  logic [31:0] mispredCount;

  perceptron_predictor dut (
    .clk(clk), .rst(rst),
    .fetchPc(fetchPc), .fetchHit(fetchHit), .fetchTarget(fetchTarget),
    .exPc(exPc), .exBranch(exBranch), .exTaken(exTaken), .exTarget(exTarget),
    .branchCount(branchCount), .mispredCount(mispredCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        hit;
    logic [31:0] tgt;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t sbq[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   stepId     = 0;

  // Reference model: plain integer weights, history as a bit list, BTB as arrays.
  int          mw [64][17];
  bit          mg [16];
  bit          mValid [64];
  logic [23:0] mTag [64];
  logic [31:0] mTgt [64];
  bit          mJmp [64];
  logic [31:0] mBranches, mMispreds;

  function automatic void modelReset();
    for (int r = 0; r < 64; r++) begin
      for (int j = 0; j < 17; j++) mw[r][j] = 0;
      mValid[r] = 0; mTag[r] = '0; mTgt[r] = '0; mJmp[r] = 0;
    end
    for (int i = 0; i < 16; i++) mg[i] = 0;
    mBranches = 0;
    mMispreds = 0;
  endfunction

  function automatic int sat(input int v);
    if (v > 127)  return 127;
    if (v < -127) return -127;
    return v;
  endfunction

  function automatic int modelY(input logic [31:0] pc);
    int row = int'(pc[7:2]);
    int y   = mw[row][0];
    for (int i = 0; i < 16; i++) y += mg[i] ? mw[row][i+1] : -mw[row][i+1];
    return y;
  endfunction

  function automatic void expectFetch(input logic [31:0] pc, output logic hit, output logic [31:0] tgt);
    int idx = int'(pc[7:2]);
    bit bh  = mValid[idx] && (mTag[idx] == pc[31:8]);
    hit = bh && (mJmp[idx] || modelY(pc) >= 0);
    tgt = bh ? mTgt[idx] : 32'd0;
  endfunction

  function automatic void modelUpdate(input logic br, input logic tk, input logic [31:0] pc, input logic [31:0] tgt);
    int row = int'(pc[7:2]);
    int y;
    if (tk) begin
      mValid[row] = 1; mTag[row] = pc[31:8]; mTgt[row] = tgt; mJmp[row] = !br;
    end
    if (br) begin
      y = modelY(pc);
      if (((y >= 0) != tk) || (y <= 44 && y >= -44)) begin
        mw[row][0] = sat(mw[row][0] + (tk ? 1 : -1));
        for (int i = 0; i < 16; i++) mw[row][i+1] = sat(mw[row][i+1] + ((mg[i] == tk) ? 1 : -1));
      end
      for (int i = 15; i > 0; i--) mg[i] = mg[i-1];
      mg[0] = tk;
      mBranches = mBranches + 32'd1;
      if ((y >= 0) != tk) mMispreds = mMispreds + 32'd1;
    end
  endfunction

  task automatic chk(input string name, input int id, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s step=%0d got=%h expected=%h", name, id, got, want);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the update edge.
  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("fetchHit", e.id, {31'd0, fetchHit}, {31'd0, e.hit});
      chk("fetchTarget", e.id, fetchTarget, e.tgt);
      chk("branchCount", e.id, branchCount, e.bc);
      chk("mispredCount", e.id, mispredCount, e.mc);
    end
  end

  task automatic step(input logic [31:0] fpc, input logic br, input logic tk,
                      input logic [31:0] epc, input logic [31:0] etgt);
    exp_t e;
    @(posedge clk); #1;
    fetchPc = fpc; exBranch = br; exTaken = tk; exPc = epc; exTarget = etgt;
    e.id = stepId++;
    expectFetch(fpc, e.hit, e.tgt);
    e.bc = mBranches;
    e.mc = mMispreds;
    sbq.push_back(e);
    modelUpdate(br, tk, epc, etgt);
  endtask

  // Reset asserted mid-cycle with an active update that must be discarded.
  task automatic midReset();
    @(posedge clk); #1;
    exBranch = 1'b1; exTaken = 1'b1; exPc = 32'h100; exTarget = 32'h999;
    #2 rst = 1'b1;
    @(posedge clk); #1;
    exBranch = 1'b0; exTaken = 1'b0;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic idle(input logic [31:0] fpc);
    step(fpc, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] randPc();
    return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 63)) << 2);
  endfunction

  initial begin
    logic [31:0] epc, fpc;
    int          kind;
    logic        tk;
    rst = 1'b1;
    fetchPc = '0; exPc = '0; exBranch = 1'b0; exTaken = 1'b0; exTarget = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle(32'h100);
    step(32'h100, 1'b1, 1'b1, 32'h100, 32'h200);
    idle(32'h100);
    step(32'h40, 1'b0, 1'b1, 32'h40, 32'h80);
    idle(32'h40);

    midReset();
    idle(32'h100);
    for (int k = 0; k < 60; k++) step(32'h100, 1'b1, 1'b0, 32'h100, 32'h0);
    idle(32'h100);

    for (int k = 0; k < 100; k++) step(32'h180, 1'b1, 1'b1, 32'h180, 32'h400);
    idle(32'h180);

    step(32'h200, 1'b1, 1'b1, 32'h100, 32'h200);
    idle(32'h200);
    step(32'h300, 1'b1, 1'b1, 32'h300, 32'h500);
    idle(32'h300);

    for (int k = 0; k < 1500; k++) begin
      epc  = randPc();
      fpc  = ($urandom_range(0, 3) == 0) ? epc : randPc();
      kind = int'($urandom_range(0, 5));
      tk   = ($urandom_range(0, 9) < 7) ^ epc[2];
      if (kind == 0)      step(fpc, 1'b0, 1'b0, epc, $urandom);
      else if (kind == 1) step(fpc, 1'b0, 1'b1, epc, $urandom);
      else                step(fpc, 1'b1, tk, epc, $urandom);
      if (k == 900) midReset();
    end
    idle(32'h0);

    for (int w = 0; w < 5 && sbq.size() > 0; w++) @(negedge clk);
    #1;
    if (sbq.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
